// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing a single-port block RAM (1-cycle registered read) between
// instruction fetch and load/store. Data wins ties, bounded by a burst counter.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS      = 256,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // RAM side
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  // debug: response owner (0 IDLE, 1 RESP_I, 2 RESP_D) and data burst count
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_burst_cnt_o
);

  // Handshake: a master raises req with its fields stable and holds them until the
  // cycle its gnt is high; that cycle is the transfer, and exactly one cycle later the
  // matching rvalid (with rdata/err) appears on the same port. There is no back-pressure
  // on responses, so every grant produces exactly one response unless reset intervenes.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  localparam logic [3:0]  BURST_MAX  = 4'(MAX_DATA_BURST);
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        store_q, store_d;
  logic [3:0]  burst_q, burst_d;
  logic        i_oor, d_oor, burst_full;

  assign i_oor      = (i_addr[31:2] >= WORD_LIMIT);
  assign d_oor      = (d_addr[31:2] >= WORD_LIMIT);
  assign burst_full = (burst_q == BURST_MAX);

  // Data wins unless fetch is waiting and data has already used its whole burst.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !(i_req && burst_full)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = i_addr;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we & ~d_oor;
      mem_be    = d_be;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (i_gnt || !i_req) begin
      burst_d = 4'd0;
    end else if (d_gnt && !burst_full) begin
      burst_d = burst_q + 4'd1;
    end
  end

  always_comb begin
    state_d = IDLE;
    err_d   = 1'b0;
    store_d = 1'b0;
    if (i_gnt) begin
      state_d = RESP_I;
      err_d   = i_oor;
    end else if (d_gnt) begin
      state_d = RESP_D;
      err_d   = d_oor;
      store_d = d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      store_q <= 1'b0;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      store_q <= store_d;
      burst_q <= burst_d;
    end
  end

  // Responses are suppressed while rst is high so a grant cut off by reset never returns.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = 32'h0;
    i_err    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = 32'h0;
    d_err    = 1'b0;
    if (!rst) begin
      case (state_q)
        RESP_I: begin
          i_rvalid = 1'b1;
          i_err    = err_q;
          if (!err_q) i_rdata = mem_rdata;
        end
        RESP_D: begin
          d_rvalid = 1'b1;
          d_err    = err_q;
          if (!err_q && !store_q) d_rdata = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM plus a transaction-level reference model
// (model memory, per-port expected-response queues, data-run counter).
module tb_mem_arbiter;
  localparam int MEM_WORDS      = 256;
  localparam int MAX_DATA_BURST = 4;
  localparam int VW             = 145;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_burst;

  logic [31:0] ram       [0:MEM_WORDS-1];
  logic [31:0] seed_mem  [0:MEM_WORDS-1];
  logic [31:0] model_mem [0:MEM_WORDS-1];
  logic        ram_init;

  // scoreboard: {err, rdata} expected one cycle after each grant
  logic [32:0] i_exp_q[$];
  logic [32:0] d_exp_q[$];
  int          run_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  logic [VW-1:0] obs_v, exp_v;
  logic          exp_i_gnt, exp_d_gnt, exp_mem_we, exp_i_rv, exp_d_rv;
  logic [32:0]   exp_i_word, exp_d_word;
  logic [31:0]   exp_mem_addr, exp_mem_wdata;
  logic [3:0]    exp_mem_be, exp_burst;
  logic [1:0]    exp_state;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_DATA_BURST(MAX_DATA_BURST)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state), .dbg_burst_cnt_o(dbg_burst)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural RAM: byte-enable write, registered read (old data on same-edge write)
  always @(posedge clk) begin
    if (ram_init) begin
      for (int w = 0; w < MEM_WORDS; w++) ram[w] <= seed_mem[w];
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr[9:2]];
  end

  function automatic logic [31:0] rand_addr();
    logic [29:0] w;
    w = 30'($urandom_range(0, MEM_WORDS + 7));
    return {w, 2'($urandom_range(0, 3))};
  endfunction

  // Reference model, evaluated once per cycle with inputs settled.
  task automatic model_step();
    logic        fetch_wins, oor;
    logic [29:0] widx;
    exp_burst  = 4'(run_cnt);
    exp_i_rv   = 1'b0;
    exp_d_rv   = 1'b0;
    exp_i_word = '0;
    exp_d_word = '0;
    exp_state  = 2'd0;
    if (i_exp_q.size() > 0) begin exp_i_word = i_exp_q.pop_front(); exp_i_rv = 1'b1; exp_state = 2'd1; end
    if (d_exp_q.size() > 0) begin exp_d_word = d_exp_q.pop_front(); exp_d_rv = 1'b1; exp_state = 2'd2; end
    exp_i_gnt     = 1'b0;
    exp_d_gnt     = 1'b0;
    exp_mem_we    = 1'b0;
    exp_mem_be    = 4'h0;
    exp_mem_wdata = 32'h0;
    exp_mem_addr  = i_addr;
    if (rst) begin
      exp_i_rv   = 1'b0;
      exp_d_rv   = 1'b0;
      exp_i_word = '0;
      exp_d_word = '0;
      run_cnt    = 0;
    end else begin
      fetch_wins = i_req && (!d_req || run_cnt >= MAX_DATA_BURST);
      if (fetch_wins) begin
        exp_i_gnt = 1'b1;
        widx = i_addr[31:2];
        oor  = (widx >= 30'(MEM_WORDS));
        i_exp_q.push_back({oor, oor ? 32'h0 : model_mem[widx[7:0]]});
        run_cnt = 0;
      end else if (d_req) begin
        exp_d_gnt     = 1'b1;
        widx          = d_addr[31:2];
        oor           = (widx >= 30'(MEM_WORDS));
        exp_mem_addr  = d_addr;
        exp_mem_be    = d_be;
        exp_mem_wdata = d_wdata;
        exp_mem_we    = d_we && !oor;
        if (oor) begin
          d_exp_q.push_back({1'b1, 32'h0});
        end else if (d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) model_mem[widx[7:0]][8*b +: 8] = d_wdata[8*b +: 8];
          d_exp_q.push_back({1'b0, 32'h0});
        end else begin
          d_exp_q.push_back({1'b0, model_mem[widx[7:0]]});
        end
        run_cnt = i_req ? run_cnt + 1 : 0;
      end
      if (!i_req) run_cnt = 0;
    end
    obs_v = {i_gnt, d_gnt, mem_we, i_rvalid, i_err, d_rvalid, d_err, i_rdata, d_rdata,
             mem_addr, mem_be, mem_wdata, dbg_state, dbg_burst};
    exp_v = {exp_i_gnt, exp_d_gnt, exp_mem_we, exp_i_rv, exp_i_word[32], exp_d_rv, exp_d_word[32],
             exp_i_word[31:0], exp_d_word[31:0], exp_mem_addr, exp_mem_be, exp_mem_wdata,
             exp_state, exp_burst};
  endtask

  // driver tasks: sample at the falling edge, drive just after the rising edge
  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    i_addr = 32'h8; d_addr = 32'hC; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      sample();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_pre%0d: observed %h expected %h", k, obs_v, exp_v); end
      advance();
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_hold%0d: observed %h expected %h", k, obs_v, exp_v); end
      n_vec++;
      if ({i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid} !== 5'b0) begin
        n_err++; $display("FAIL reset_quiet%0d: gnt/we/rvalid %b required 00000", k, {i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid});
      end
      advance();
    end
    rst = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_release: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({i_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: i/d gnt %b required 01", {i_gnt, d_gnt}); end
    advance();
    d_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_after1: observed %h expected %h", obs_v, exp_v); end
    advance();
    i_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_after2: observed %h expected %h", obs_v, exp_v); end
    advance();
  endtask

  task automatic test_store_load();
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_be = 4'b0101; d_wdata = 32'hAABB_CCDD;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL store_cyc0: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({d_gnt, mem_we} !== 2'b11) begin n_err++; $display("FAIL store_grant: d_gnt/mem_we %b required 11", {d_gnt, mem_we}); end
    advance();
    d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL store_cyc1: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({d_gnt, d_rvalid, d_rdata} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL store_resp: gnt/rvalid %b rdata %h required 11 00000000", {d_gnt, d_rvalid}, d_rdata);
    end
    advance();
    d_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL store_cyc2: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h00BB_00DD}) begin
      n_err++; $display("FAIL load_after_store: rvalid/err %b rdata %h required 10 00bb00dd", {d_rvalid, d_err}, d_rdata);
    end
    advance();
  endtask

  task automatic test_idle_fetch();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h4;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL fetch_cyc0: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({i_gnt, d_gnt, dbg_burst} !== 6'b10_0000) begin
      n_err++; $display("FAIL fetch_grant: gnt %b burst %0d required 10 / 0", {i_gnt, d_gnt}, dbg_burst);
    end
    advance();
    i_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL fetch_cyc1: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({i_rvalid, i_err, i_rdata, dbg_burst} !== {2'b10, seed_mem[1], 4'd0}) begin
      n_err++; $display("FAIL fetch_data: rvalid/err %b rdata %h burst %0d required 10 %h 0", {i_rvalid, i_err}, i_rdata, dbg_burst, seed_mem[1]);
    end
    advance();
  endtask

  task automatic test_contention();
    logic ig, dg;
    i_req = 1'b1; d_req = 1'b1; i_addr = {22'h0, 8'($urandom), 2'b00};
    d_addr = {22'h0, 8'($urandom), 2'b00}; d_we = 1'($urandom); d_be = 4'($urandom); d_wdata = $urandom;
    for (int k = 0; k < 15; k++) begin
      sample();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL contend%0d: observed %h expected %h", k, obs_v, exp_v); end
      n_vec++;
      if ({i_gnt, d_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL contend_pattern%0d: i/d gnt %b required %b", k, {i_gnt, d_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
      end
      ig = i_gnt; dg = d_gnt;
      advance();
      if (ig) i_addr = {22'h0, 8'($urandom), 2'b00};
      if (dg) begin
        d_addr = {22'h0, 8'($urandom), 2'b00}; d_we = 1'($urandom); d_be = 4'($urandom); d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL contend_drain: observed %h expected %h", obs_v, exp_v); end
    advance();
  endtask

  task automatic test_out_of_range();
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h400; d_wdata = $urandom;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL oor_cyc0: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({d_gnt, mem_we} !== 2'b10) begin n_err++; $display("FAIL oor_store_blocked: d_gnt/mem_we %b required 10", {d_gnt, mem_we}); end
    advance();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h400;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL oor_cyc1: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL oor_store_resp: rvalid/err %b rdata %h required 11 00000000", {d_rvalid, d_err}, d_rdata);
    end
    n_vec++;
    if (ram[0] !== seed_mem[0]) begin n_err++; $display("FAIL oor_word0: ram[0] %h required %h", ram[0], seed_mem[0]); end
    advance();
    i_addr = 32'h3FC;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL oor_cyc2: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({i_rvalid, i_err, i_rdata} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL oor_fetch_resp: rvalid/err %b rdata %h required 11 00000000", {i_rvalid, i_err}, i_rdata);
    end
    advance();
    i_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL oor_cyc3: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({i_rvalid, i_err, i_rdata} !== {2'b10, seed_mem[255]}) begin
      n_err++; $display("FAIL last_word_fetch: rvalid/err %b rdata %h required 10 %h", {i_rvalid, i_err}, i_rdata, seed_mem[255]);
    end
    advance();
  endtask

  task automatic test_reset_midflight();
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d_addr = {22'h0, 8'($urandom), 2'b00};
      sample();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL midrst_cyc%0d: observed %h expected %h", k, obs_v, exp_v); end
      advance();
    end
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL midrst_cyc5: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if (i_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_grant: i_gnt %b required 1", i_gnt); end
    advance();
    i_req = 1'b0; rst = 1'b1;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL midrst_cyc6: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if (i_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_no_rvalid: i_rvalid %b required 0", i_rvalid); end
    advance();
    rst = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL midrst_cyc7: observed %h expected %h", obs_v, exp_v); end
    n_vec++;
    if ({dbg_state, dbg_burst, i_rvalid} !== 7'b0) begin
      n_err++; $display("FAIL midrst_idle: state %0d burst %0d rvalid %b required 0 0 0", dbg_state, dbg_burst, i_rvalid);
    end
    advance();
  endtask

  task automatic test_random_traffic();
    logic ig, dg;
    int   i_wait;
    i_req = 1'b0; d_req = 1'b0; i_wait = 0;
    for (int k = 0; k < 400; k++) begin
      sample();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL random%0d: observed %h expected %h", k, obs_v, exp_v); end
      if (i_req) begin
        i_wait++;
        if (i_gnt) begin
          n_vec++;
          if (i_wait > MAX_DATA_BURST + 1) begin n_err++; $display("FAIL fetch_starved%0d: waited %0d cycles, bound %0d", k, i_wait, MAX_DATA_BURST + 1); end
          i_wait = 0;
        end
      end
      ig = i_gnt; dg = d_gnt;
      advance();
      if (!i_req || ig) begin
        i_req = ($urandom_range(0, 3) != 0); i_addr = rand_addr();
      end
      if (!d_req || dg) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = rand_addr(); d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    sample();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL random_drain: observed %h expected %h", obs_v, exp_v); end
    advance();
  endtask

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) begin
      seed_mem[w]  = $urandom;
      model_mem[w] = seed_mem[w];
    end
    seed_mem[4] = 32'h0; model_mem[4] = 32'h0;
    run_cnt = 0;
    rst = 1'b1; ram_init = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; ram_init = 1'b0;
    test_reset();
    test_store_load();
    test_idle_fetch();
    test_contention();
    test_out_of_range();
    test_reset_midflight();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter placed in front of the single-port program/data block RAM, which has a registered read port with 1-cycle latency and byte-enable writes. It shares that RAM between the core's instruction-fetch port (read-only) and its load/store port (read/write with byte enables). Data accesses have priority, and a bounded-burst counter guarantees fetch forward progress. The block also tracks which master owns the in-flight response, routes the RAM's registered read data back to that master, and flags out-of-range word addresses.

## Interface
- MEM_WORDS, 256: number of valid 32-bit words. Word index is addr[31:2]; an index ≥ MEM_WORDS is out of range.
- MAX_DATA_BURST, 4: maximum consecutive data grants while fetch is waiting (range 1..15).

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until granted
- i_addr  in  32  fetch byte address (bits [1:0] ignored)
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch response valid, 1 cycle after i_gnt
- i_rdata  out  32  fetch read data
- i_err  out  1  with i_rvalid: address was out of range
- d_req  in  1  load/store request; held with all fields stable until granted
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data response (load data or store completion), 1 cycle after d_gnt
- d_rdata  out  32  load data (0 for stores)
- d_err  out  1  with d_rvalid: address was out of range
- mem_addr  out  32  to RAM addr
- mem_be  out  4  to RAM be
- mem_wdata  out  32  to RAM data_in
- mem_we  out  1  to RAM we
- mem_rdata  in  32  from RAM data_out (registered in RAM)

## Operation
- Grant decision (combinational, each cycle, only when rst=0):
  - If only one request is active, grant it.
  - If both are active, grant data, unless burst_cnt == MAX_DATA_BURST; then grant fetch.
- At most one grant per cycle. The arbiter never grants when no request is active.
- Granted master drives the mem_* outputs. A fetch grant sets mem_we=0 and mem_be=0. A data grant passes d_we, d_be and d_wdata through.
- With no grant, the mux defaults to mem_addr=i_addr, mem_we=0, mem_be=0 and mem_wdata=0.
- Out-of-range grant: the grant is still given, but mem_we is forced to 0. The response carries err=1 and rdata=0.
- burst_cnt (4 bits):
  - Increments on a data grant while i_req=1.
  - Clears on any fetch grant, or in any cycle with i_req=0.
  - Saturates at MAX_DATA_BURST.
- Response-owner state machine, registered each cycle:
  - States: IDLE, RESP_I, RESP_D.
  - Next state is RESP_I on a fetch grant, RESP_D on a data grant, otherwise IDLE.
  - An err bit and a "was store" bit are registered alongside the state.
- Response outputs by state:
  - RESP_I: i_rvalid=1, i_rdata=mem_rdata (0 if err), i_err=err.
  - RESP_D: d_rvalid=1, d_err=err. d_rdata=mem_rdata for loads; 0 for stores or when err=1.
  - Inactive port: rvalid=0, rdata=0, err=0.
- Back-to-back grants are allowed every cycle; full throughput is 1 access per cycle.

## Timing
- Reset (rst=1 at an edge):
  - Next cycle: state=IDLE, burst_cnt=0, all rvalid/err/rdata=0.
  - While rst=1, i_gnt=d_gnt=0 and mem_we=0 regardless of requests.
- Reset mid-operation: a grant issued in the cycle before rst asserts produces no rvalid. The state is forced to IDLE.
- Latency: grant in cycle N gives rvalid in cycle N+1 with RAM data read at edge N.
- Store: the byte write occurs at edge N. A load to the same word granted in N+1 returns the new data in N+2.
- Fetch starvation bound: with d_req held high continuously, fetch is granted within MAX_DATA_BURST+1 cycles of i_req rising.
- Simultaneous grant and response in the same cycle is normal (pipelined). The response always belongs to the previous cycle's grant.

## Test plan
- Reset: hold rst=1 with i_req=d_req=1 for 3 cycles. Expect i_gnt=d_gnt=mem_we=0 and i_rvalid=d_rvalid=0. First grant appears in the cycle rst drops.
- Store then load:
  - Cycle 0: d_we=1, d_addr=0x10, d_be=4'b0101, d_wdata=0xAABBCCDD over word 0x00000000.
  - Cycle 1: d_rvalid=1, d_rdata=0.
  - Load 0x10 granted in cycle 1 returns 0x00BB00DD in cycle 2.
- Contention, MAX_DATA_BURST=4: i_req and d_req both held high from cycle 0. Grants are D,D,D,D,I,D,D,D,D,I… Each rvalid goes to the correct port one cycle after its grant, with no lost or duplicated responses.
- Out-of-range: d_we=1, d_addr=0x400 (word 256). Expect mem_we=0 and RAM word 0 unchanged. Next cycle d_rvalid=1, d_err=1, d_rdata=0. A fetch from 0x400 gives i_err=1.
- Reset mid-flight: grant a fetch of 0x0 in cycle 5 and assert rst in cycle 6. Expect i_rvalid=0 in cycle 6; in cycle 7 state=IDLE and burst_cnt=0.
- Idle fetch: i_req=1 at 0x4 alone. Expect i_gnt same cycle and i_rvalid next cycle with the RAM word 1 contents; burst_cnt stays 0.
